// File: rtl/core_seq.sv
// core_seq: multi-cycle RV32I-subset sequencer for verycore (pc, IR, mem port).
// Define CORE_SEQ_INSTRET_EN to build the retired-instruction counter.
module core_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [2:0]  alu_funct,
  output logic        alu_mod,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_n,
  input  logic        cond_n,
  output logic [31:0] pc,
  output logic        trap,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_AWAIT,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] ir;
  logic [31:0] res;
  logic [31:0] npc;
  logic [31:0] pc_n;
  logic [31:0] tgt;
  logic [31:0] opb;
  logic [31:0] wb_data;
  logic        hs;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        is_op;
  logic        is_opi;
  logic        is_br;
  logic        is_lw;
  logic        is_sw;
  logic        is_lui;
  logic        is_jal;
  logic        is_ls;
  logic        legal;
  logic        mod_sel;
  logic        wr_en;

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign hs  = mem_req & mem_ack;
  assign opc = ir[6:0];
  assign f3  = ir[14:12];

  assign is_op  = opc == 7'b0110011;
  assign is_opi = opc == 7'b0010011;
  assign is_br  = opc == 7'b1100011;
  assign is_lw  = opc == 7'b0000011;
  assign is_sw  = opc == 7'b0100011;
  assign is_lui = opc == 7'b0110111;
  assign is_jal = opc == 7'b1101111;
  assign is_ls  = is_lw | is_sw;

  assign legal = is_op | is_opi | is_br | is_lui | is_jal
               | (is_ls && f3 == 3'b010);

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'h000};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  assign rf_raddr1 = ir[19:15];
  assign rf_raddr2 = ir[24:20];
  assign rf_waddr  = ir[11:7];

  // SRA/SRAI and SUB share the funct7[5] select bit.
  assign mod_sel = is_op ? ir[30]
                 : (is_opi && f3 == 3'b101) ? ir[30]
                 : 1'b0;

  assign wr_en = (ir[11:7] != 5'd0) && !is_br && !is_sw;

  // Second alu operand: register or format-specific immediate.
  always_comb begin
    opb = rf_rdata2;
    unique case (1'b1)
      is_opi, is_lw: opb = imm_i;
      is_sw:         opb = imm_s;
      default:       opb = rf_rdata2;
    endcase
  end

  // Branch/jump target, valid once cond_n is valid.
  always_comb begin
    tgt = pc + 32'd4;
    unique case (1'b1)
      is_jal:          tgt = pc + imm_j;
      is_br && cond_n: tgt = pc + imm_b;
      default:         tgt = pc + 32'd4;
    endcase
  end

  // Writeback data source.
  always_comb begin
    wb_data = res;
    unique case (1'b1)
      is_lui:  wb_data = imm_u;
      is_jal:  wb_data = pc + 32'd4;
      default: wb_data = res;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_n;
  end

  // Next state, datapath strobes and pc update.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    rf_we     = 1'b0;
    rf_wdata  = 32'h0;
    alu_a     = 32'h0;
    alu_b     = 32'h0;
    alu_funct = 3'b000;
    alu_mod   = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (hs) state_n = S_DECODE;
      end
      S_DECODE: begin
        state_n = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        alu_a     = rf_rdata1;
        alu_b     = opb;
        alu_funct = is_ls ? 3'b000 : f3;
        alu_mod   = is_ls ? 1'b0 : mod_sel;
        state_n   = S_AWAIT;
      end
      S_AWAIT: begin
        if (tgt[1:0] != 2'b00) state_n = S_TRAP;
        else if (is_ls)        state_n = S_MEM;
        else                   state_n = S_WB;
      end
      S_MEM: begin
        if (hs) state_n = S_WB;
      end
      S_WB: begin
        rf_we    = wr_en;
        rf_wdata = wr_en ? wb_data : 32'h0;
        pc_n     = npc;
        state_n  = S_FETCH;
      end
      S_TRAP: begin
        pc_n    = TRAP_PC;
        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  // Architectural and holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= RESET_PC;
      ir   <= 32'h0;
      res  <= 32'h0;
      npc  <= 32'h0;
      trap <= 1'b0;
    end else begin
      pc <= pc_n;
      if (state == S_FETCH && hs) ir <= mem_rdata;
      if (state == S_AWAIT) begin
        res <= alu_n;
        npc <= tgt;
      end
      if (state == S_MEM && hs) res <= mem_rdata;
      if (state == S_TRAP) trap <= 1'b1;
    end
  end

  // Memory port: request launched on entry, held until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else if (hs) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end else if (state == S_FETCH && !mem_req) begin
      mem_req  <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= pc;
    end else if (state != S_FETCH && state_n == S_FETCH) begin
      mem_req  <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= pc_n;
    end else if (state == S_AWAIT && state_n == S_MEM) begin
      mem_req   <= 1'b1;
      mem_we    <= is_sw;
      mem_addr  <= {alu_n[31:2], 2'b00};
      mem_wdata <= is_sw ? rf_rdata2 : 32'h0;
    end
  end

`ifdef CORE_SEQ_INSTRET_EN
  logic [31:0] cnt;

  // One count per completed writeback; wraps at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= 32'h0;
    else if (state == S_WB) cnt <= cnt + 32'd1;
  end

  assign instret = cnt;
`else
  assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: program-level bench for core_seq with ram, regfile and alu models.
// Expected results come from an instruction-level model of the program.
module tb_core_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  alu_funct;
  logic        alu_mod;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_n;
  logic        cond_n;
  logic [31:0] pc;
  logic        trap;
  logic [31:0] instret;

`ifdef CORE_SEQ_INSTRET_EN
  localparam int IE = 1;
`else
  localparam int IE = 0;
`endif

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;

  always #5 clk = ~clk;

  core_seq dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_funct(alu_funct), .alu_mod(alu_mod),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_n(alu_n), .cond_n(cond_n),
    .pc(pc), .trap(trap), .instret(instret)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:255];
  logic [31:0] dwr [int];
  logic [31:0] rf [0:31];
  int          ack_dly;
  bit          ack_rand;
  logic [31:0] stall_addr;
  int          wcnt;
  int          cur_dly;
  int          cyc;

  int          wq_rd[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  logic [31:0] mod_pc[$];
  int          st_cnt;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  int          stab_err;
  logic        p_req, p_ack, p_we;
  logic [31:0] p_addr, p_wdata;

  function automatic logic [31:0] rv_alu(logic [2:0] f, logic alt,
                                         logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic rv_cond(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'h0 : rf[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'h0 : rf[rf_raddr2];

  // Registered alu/cond unit: result one cycle after operands.
  always @(posedge clk) begin
    alu_n  <= rv_alu(alu_funct, alu_mod, alu_a, alu_b);
    cond_n <= rv_cond(alu_funct, alu_a, alu_b);
  end

  // Regfile and port activity log.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
      wq_rd.delete();
      wq_data.delete();
      wq_cyc.delete();
      mod_pc.delete();
      st_cnt = 0;
      stab_err = 0;
    end else begin
      if (rf_we) begin
        wq_rd.push_back(int'(rf_waddr));
        wq_data.push_back(rf_wdata);
        wq_cyc.push_back(cyc);
        if (rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
      end
      if (alu_mod) mod_pc.push_back(pc);
      if (mem_req && mem_ack && mem_we) begin
        st_cnt++;
        st_addr = mem_addr;
        st_data = mem_wdata;
      end
      if (mem_req && p_req && !p_ack &&
          (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
        stab_err++;
    end
    p_req = mem_req;
    p_ack = mem_ack;
    p_we = mem_we;
    p_addr = mem_addr;
    p_wdata = mem_wdata;
  end

  // Ram: ack after a programmable wait; never acks a fetch of stall_addr.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!rst_n) begin
      wcnt = 0;
      dwr.delete();
    end else if (!mem_req) begin
      wcnt = 0;
    end else if (!(mem_addr == stall_addr && !mem_we)) begin
      if (wcnt == 0) cur_dly = ack_rand ? int'($urandom_range(0, 2)) : ack_dly;
      if (wcnt >= cur_dly) begin
        mem_ack = 1'b1;
        mem_rdata = dwr.exists(int'(mem_addr[9:2])) ?
                    dwr[int'(mem_addr[9:2])] : mem[mem_addr[9:2]];
        if (mem_we) dwr[int'(mem_addr[9:2])] = mem_wdata;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3,
                                        int rd, logic [6:0] op);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3,
                                        int rd, logic [6:0] op);
    logic [11:0] im;
    im = imm[11:0];
    return {im, 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    logic [11:0] im;
    im = imm[11:0];
    return {im[11:5], 5'(rs2), 5'(rs1), 3'd2, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [12:0] im;
    im = imm[12:0];
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3),
            im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [20:0] im;
    im = imm[20:0];
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic int q_rd(int i);
    if (i < wq_rd.size()) return wq_rd[i];
    return -1;
  endfunction

  function automatic logic [31:0] q_dat(int i);
    if (i < wq_data.size()) return wq_data[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic start(input int dly, input bit rnd, input logic [31:0] stall);
    ack_dly = dly;
    ack_rand = rnd;
    stall_addr = stall;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int limit, input string name);
    int n;
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == stall_addr) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) begin
      failures++;
      $display("FAIL %s_done: no fetch of %h after %0d cycles, required before %0d",
               name, stall_addr, n, limit);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== 32'h0) begin
      failures++; $display("FAIL reset_pc: got %h, required 0", pc);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      failures++; $display("FAIL reset_req: req=%b we=%b, required 0 0", mem_req, mem_we);
    end
    checks++;
    if (trap !== 1'b0 || rf_we !== 1'b0) begin
      failures++; $display("FAIL reset_flags: trap=%b rf_we=%b, required 0 0", trap, rf_we);
    end
    checks++;
    if (instret !== 32'h0) begin
      failures++; $display("FAIL reset_instret: got %h, required 0", instret);
    end
  endtask

  task automatic test_alu();
    clear_mem();
    mem[0] = enc_i(5, 0, 0, 1, OPI);
    mem[1] = enc_r(32, 1, 1, 0, 2, OP);
    start(0, 0, 32'h8);
    run(200, "alu");
    checks++;
    if (q_rd(0) !== 1 || q_dat(0) !== 32'd5) begin
      failures++; $display("FAIL alu_addi: rd=%0d data=%h, required rd=1 data=5", q_rd(0), q_dat(0));
    end
    checks++;
    if (q_rd(1) !== 2 || q_dat(1) !== 32'd0 || wq_rd.size() != 2) begin
      failures++; $display("FAIL alu_sub: rd=%0d data=%h n=%0d, required rd=2 data=0 n=2",
                           q_rd(1), q_dat(1), wq_rd.size());
    end
    checks++;
    if (mod_pc.size() != 1 || (mod_pc.size() == 1 && mod_pc[0] !== 32'h4)) begin
      failures++; $display("FAIL alu_mod: %0d pulses, required one at pc 4", mod_pc.size());
    end
    checks++;
    if (wq_cyc.size() != 2 || (wq_cyc.size() == 2 && wq_cyc[1] - wq_cyc[0] != 5)) begin
      failures++; $display("FAIL alu_cpi: %0d writes, spacing not 5 cycles", wq_cyc.size());
    end
  endtask

  task automatic test_load_store();
    clear_mem();
    mem[0]  = enc_j(32'h40, 0);
    mem[16] = enc_i(5, 0, 0, 1, OPI);
    mem[17] = enc_s(8, 1, 0);
    mem[18] = enc_i(8, 0, 2, 3, LD);
    start(3, 0, 32'h4c);
    run(500, "ldst");
    checks++;
    if (q_rd(1) !== 3 || q_dat(1) !== 32'd5 || wq_rd.size() != 2) begin
      failures++; $display("FAIL ldst_lw: rd=%0d data=%h n=%0d, required rd=3 data=5 n=2",
                           q_rd(1), q_dat(1), wq_rd.size());
    end
    checks++;
    if (st_cnt != 1 || st_addr !== 32'h8 || st_data !== 32'd5) begin
      failures++; $display("FAIL ldst_sw: stores=%0d addr=%h data=%h, required 1 8 5",
                           st_cnt, st_addr, st_data);
    end
    checks++;
    if (stab_err != 0) begin
      failures++; $display("FAIL ldst_hold: %0d unstable cycles, required 0", stab_err);
    end
    checks++;
    if (!dwr.exists(2) || dwr[2] !== 32'd5) begin
      failures++; $display("FAIL ldst_ram: word 2 not 5, required 5");
    end
  endtask

  task automatic test_branch();
    clear_mem();
    mem[0] = enc_j(32'h20, 0);
    mem[8] = enc_b(-8, 0, 0, 0);
    mem[6] = enc_i(7, 0, 0, 5, OPI);
    start(0, 1, 32'h1c);
    run(300, "beq");
    checks++;
    if (q_rd(0) !== 5 || q_dat(0) !== 32'd7 || wq_rd.size() != 1 || pc !== 32'h1c) begin
      failures++; $display("FAIL beq_taken: rd=%0d data=%h pc=%h, required rd=5 data=7 pc=1c",
                           q_rd(0), q_dat(0), pc);
    end
    clear_mem();
    mem[0] = enc_j(32'h20, 0);
    mem[8] = enc_b(8, 0, 0, 1);
    mem[9] = enc_i(9, 0, 0, 6, OPI);
    start(0, 1, 32'h28);
    run(300, "bne");
    checks++;
    if (q_rd(0) !== 6 || q_dat(0) !== 32'd9 || wq_rd.size() != 1) begin
      failures++; $display("FAIL bne_fall: rd=%0d data=%h n=%0d, required rd=6 data=9 n=1",
                           q_rd(0), q_dat(0), wq_rd.size());
    end
  endtask

  task automatic test_trap();
    logic [31:0] prog [2];
    prog[0] = enc_j(6, 1);
    prog[1] = 32'h0000_0073;
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      mem[0] = prog[k];
      start(0, 0, 32'h100);
      run(200, "trap");
      checks++;
      if (trap !== 1'b1 || pc !== 32'h100) begin
        failures++; $display("FAIL trap_%0d: trap=%b pc=%h, required 1 100", k, trap, pc);
      end
      checks++;
      if (wq_rd.size() != 0 || instret !== 32'h0) begin
        failures++; $display("FAIL trap_%0d_nowb: writes=%0d instret=%0d, required 0 0",
                             k, wq_rd.size(), instret);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    int n;
    clear_mem();
    mem[0] = enc_i(5, 0, 0, 1, OPI);
    mem[1] = enc_i(32'h40, 0, 2, 2, LD);
    start(20, 0, 32'h8);
    n = 0;
    while (!(mem_req && mem_addr == 32'h40) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300 || instret !== 32'(IE)) begin
      failures++; $display("FAIL rstmem_reach: cycles=%0d instret=%0d, required load req and %0d",
                           n, instret, IE);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || pc !== 32'h0 || instret !== 32'h0) begin
      failures++; $display("FAIL rstmem_abort: req=%b pc=%h instret=%0d, required 0 0 0",
                           mem_req, pc, instret);
    end
  endtask

  task automatic test_instret();
    clear_mem();
    mem[0] = enc_i(1, 0, 0, 1, OPI);
    mem[1] = enc_i(2, 1, 0, 2, OPI);
    mem[2] = enc_i(3, 2, 0, 0, OPI);
    start(1, 0, 32'hc);
    run(200, "instret");
    checks++;
    if (instret !== 32'(3 * IE)) begin
      failures++; $display("FAIL instret_3: got %0d, required %0d", instret, 3 * IE);
    end
  endtask

  task automatic test_random();
    localparam int N = 12;
    logic [31:0] x [32];
    int          exp_rd[$];
    logic [31:0] exp_d[$];
    logic [31:0] ins;
    logic [31:0] res;
    int          kind, rd, rs1, rs2, f3, alt, imm;
    for (int k = 0; k < 3; k++) begin
      clear_mem();
      exp_rd.delete();
      exp_d.delete();
      for (int r = 0; r < 32; r++) x[r] = 32'h0;
      for (int i = 0; i < N; i++) begin
        kind = $urandom_range(0, 3);
        rd = $urandom_range(0, 7);
        rs1 = $urandom_range(0, 7);
        rs2 = $urandom_range(0, 7);
        f3 = $urandom_range(0, 7);
        alt = (f3 == 0 || f3 == 5) ? int'($urandom_range(0, 1)) : 0;
        if (kind == 0) begin
          ins = enc_r(alt * 32, rs2, rs1, f3, rd, OP);
        end else if (kind == 3) begin
          ins = {20'($urandom), 5'(rd), 7'b0110111};
        end else begin
          if (f3 == 1) imm = $urandom_range(0, 31);
          else if (f3 == 5) imm = (alt * 1024) + int'($urandom_range(0, 31));
          else imm = $urandom_range(0, 4095);
          ins = enc_i(imm, rs1, f3, rd, OPI);
        end
        mem[i] = ins;
        if (ins[6:0] == OP)
          res = rv_alu(ins[14:12], ins[30], x[ins[19:15]], x[ins[24:20]]);
        else if (ins[6:0] == OPI)
          res = rv_alu(ins[14:12], ins[14:12] == 3'd5 && ins[30],
                       x[ins[19:15]], {{20{ins[31]}}, ins[31:20]});
        else
          res = {ins[31:12], 12'h000};
        if (ins[11:7] != 5'd0) begin
          x[ins[11:7]] = res;
          exp_rd.push_back(int'(ins[11:7]));
          exp_d.push_back(res);
        end
      end
      start(0, 1, 32'(4 * N));
      run(1000, "random");
      checks++;
      if (wq_rd.size() != exp_rd.size()) begin
        failures++; $display("FAIL rand%0d_count: %0d writes, required %0d",
                             k, wq_rd.size(), exp_rd.size());
      end
      for (int i = 0; i < exp_rd.size(); i++) begin
        checks++;
        if (q_rd(i) !== exp_rd[i] || q_dat(i) !== exp_d[i]) begin
          failures++; $display("FAIL rand%0d_wr%0d: rd=%0d data=%h, required rd=%0d data=%h",
                               k, i, q_rd(i), q_dat(i), exp_rd[i], exp_d[i]);
        end
      end
      checks++;
      if (instret !== 32'(N * IE)) begin
        failures++; $display("FAIL rand%0d_instret: got %0d, required %0d", k, instret, N * IE);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ack_dly = 0;
    ack_rand = 1'b0;
    stall_addr = 32'hffff_fffc;
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_trap();
    test_reset_mid_mem();
    test_instret();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
